// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock sequencer.
// Contents:
//   lock_state_e : FSM state type; the codes also drive the display
//   DEFAULT_PW   : stored password after reset
//   clog2        : ceiling log2, used to size counters
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_CHG_AUTH = 3'd2,
    ST_CHG_NEW  = 3'd3,
    ST_ALARM    = 3'd4
  } lock_state_e;

  localparam logic [3:0] DEFAULT_PW = 4'b0110;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector that turns a button level into a one-cycle pulse.
// The history register is preset to 1 in reset, so a button that is held
// through reset gives no pulse until it is released and pressed again.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   level_i : raw button level
//   pulse_o : high for one cycle after a 0->1 transition of level_i
module edge_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/lock_sequencer.sv
// Sequencing controller for the keypad password lock. Holds the stored
// password, detects enter/change presses, and runs the open, change-password
// and alarm sequences with a shared failed-attempt limit, an auto-relock
// timer and an inactivity timeout. All outputs are registered.
// Ports:
//   Clock      : system clock, rising edge
//   Reset      : synchronous active-high reset
//   enter      : enter button level
//   change     : change button level
//   userpass   : password switches
//   OPEN       : door open indicator
//   ALARM      : sticky alarm indicator (cleared only by Reset)
//   NEW        : high while waiting for the new password
//   state_o    : current state code for the display
//   tries_left : MAX_TRIES minus consecutive failed attempts
// Handshake: none; enter/change are levels, each press is one event.
module lock_sequencer #(
  parameter int                PW_W           = 4,
  parameter logic [PW_W-1:0]   DEFAULT_PW     = lock_pkg::DEFAULT_PW,
  parameter int                MAX_TRIES      = 3,
  parameter int                OPEN_CYCLES    = 8,
  parameter int                TIMEOUT_CYCLES = 32
) (
  input  logic                                   Clock,
  input  logic                                   Reset,
  input  logic                                   enter,
  input  logic                                   change,
  input  logic [PW_W-1:0]                        userpass,
  output logic                                   OPEN,
  output logic                                   ALARM,
  output logic                                   NEW,
  output logic [2:0]                             state_o,
  output logic [lock_pkg::clog2(MAX_TRIES+1)-1:0] tries_left
);

  import lock_pkg::*;

  localparam int TMR_MAX = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = (clog2(TMR_MAX) < 1) ? 1 : clog2(TMR_MAX);
  localparam int TRY_W   = clog2(MAX_TRIES + 1);

  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TRY_W-1:0] MAX_F     = TRY_W'(MAX_TRIES);

  lock_state_e       state_q, state_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic [TRY_W-1:0]  fails_q, fails_d, fails_inc;
  logic [TMR_W-1:0]  timer_q, timer_d, timer_dec;
  logic              open_q, alarm_q, new_q;
  logic [TRY_W-1:0]  tries_q;

  logic enter_p, change_p;
  logic enter_ev, change_ev;
  logic match, fail_ev, timer_zero;

  edge_pulse u_enter_edge (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .level_i (enter),
    .pulse_o (enter_p)
  );

  edge_pulse u_change_edge (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .level_i (change),
    .pulse_o (change_p)
  );

  // Enter wins a simultaneous press; the change event is dropped.
  assign enter_ev   = enter_p;
  assign change_ev  = change_p & ~enter_p;
  assign match      = (userpass == pw_q);
  assign timer_zero = (timer_q == '0);
  assign timer_dec  = timer_zero ? '0 : timer_q - 1'b1;
  assign fails_inc  = fails_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    fails_d = fails_q;
    timer_d = timer_q;
    fail_ev = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enter_ev && match) begin
          state_d = ST_UNLOCKED;
          fails_d = '0;
          timer_d = OPEN_LOAD;
        end else if (enter_ev) begin
          fail_ev = 1'b1;
        end else if (change_ev) begin
          state_d = ST_CHG_AUTH;
          timer_d = TOUT_LOAD;
        end
      end

      ST_UNLOCKED: begin
        if (enter_ev) begin
          state_d = ST_IDLE;
        end else if (change_ev) begin
          // Already authenticated, so go straight to entering the new password.
          state_d = ST_CHG_NEW;
          timer_d = TOUT_LOAD;
        end else if (timer_zero) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_dec;
        end
      end

      ST_CHG_AUTH: begin
        if (change_ev || (enter_ev && match)) begin
          state_d = ST_CHG_NEW;
          fails_d = '0;
          timer_d = TOUT_LOAD;
        end else if (enter_ev) begin
          fail_ev = 1'b1;
          timer_d = TOUT_LOAD;
        end else if (timer_zero) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_dec;
        end
      end

      ST_CHG_NEW: begin
        if (enter_ev || change_ev) begin
          pw_d    = userpass;
          state_d = ST_IDLE;
        end else if (timer_zero) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_dec;
        end
      end

      ST_ALARM: begin
        state_d = ST_ALARM;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared failure rule for IDLE and CHG_AUTH; the alarm overrides any
    // state chosen above.
    if (fail_ev) begin
      if (fails_q != MAX_F) begin
        fails_d = fails_inc;
      end
      if (fails_inc == MAX_F) begin
        state_d = ST_ALARM;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pw_q    <= DEFAULT_PW;
      fails_q <= '0;
      timer_q <= '0;
      open_q  <= 1'b0;
      alarm_q <= 1'b0;
      new_q   <= 1'b0;
      tries_q <= MAX_F;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      open_q  <= (state_d == ST_UNLOCKED);
      alarm_q <= (state_d == ST_ALARM);
      new_q   <= (state_d == ST_CHG_NEW);
      tries_q <= MAX_F - fails_d;
    end
  end

  assign OPEN       = open_q;
  assign ALARM      = alarm_q;
  assign NEW        = new_q;
  assign state_o    = state_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run checked against a
// behavioural model of the lock's rules.
module tb_lock_sequencer;

  localparam int MAX_TRIES      = 3;
  localparam int OPEN_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 32;
  localparam logic [3:0] DEF_PW = 4'b0110;

  // ---------------- clock / reset / DUT ----------------
  logic       Clock = 1'b0;
  logic       Reset;
  logic       enter;
  logic       change;
  logic [3:0] userpass;
  logic       OPEN;
  logic       ALARM;
  logic       NEW;
  logic [2:0] state_o;
  logic [1:0] tries_left;

  always #5 Clock = ~Clock;

  lock_sequencer #(
    .PW_W           (4),
    .DEFAULT_PW     (DEF_PW),
    .MAX_TRIES      (MAX_TRIES),
    .OPEN_CYCLES    (OPEN_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .enter      (enter),
    .change     (change),
    .userpass   (userpass),
    .OPEN       (OPEN),
    .ALARM      (ALARM),
    .NEW        (NEW),
    .state_o    (state_o),
    .tries_left (tries_left)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 open, 2 verifying for change, 3 entering new pw, 4 alarm.
  // left: cycles the current timed mode may still last without an event.
  logic [3:0] m_pw;
  int         m_mode;
  int         m_fails;
  int         m_left;
  bit         m_prev_en;
  bit         m_prev_ch;
  bit         score_on = 1'b0;
  logic [7:0] exp_q[$];

  task automatic model_fail();
    if (m_fails < MAX_TRIES) m_fails++;
    if (m_fails >= MAX_TRIES) m_mode = 4;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit ch, input logic [3:0] pw);
    bit ev_en, ev_ch, ok;
    if (rst) begin
      m_pw = DEF_PW; m_mode = 0; m_fails = 0; m_left = 0;
      m_prev_en = 1'b1; m_prev_ch = 1'b1;
    end else begin
      ev_en = en && !m_prev_en;
      ev_ch = ch && !m_prev_ch && !ev_en;
      m_prev_en = en;
      m_prev_ch = ch;
      ok = (pw == m_pw);
      case (m_mode)
        0: begin
          if (ev_en && ok) begin m_mode = 1; m_fails = 0; m_left = OPEN_CYCLES; end
          else if (ev_en) model_fail();
          else if (ev_ch) begin m_mode = 2; m_left = TIMEOUT_CYCLES; end
        end
        1: begin
          if (ev_en) m_mode = 0;
          else if (ev_ch) begin m_mode = 3; m_left = TIMEOUT_CYCLES; end
          else begin m_left--; if (m_left == 0) m_mode = 0; end
        end
        2: begin
          if (ev_ch || (ev_en && ok)) begin m_mode = 3; m_fails = 0; m_left = TIMEOUT_CYCLES; end
          else if (ev_en) begin m_left = TIMEOUT_CYCLES; model_fail(); end
          else begin m_left--; if (m_left == 0) m_mode = 0; end
        end
        3: begin
          if (ev_en || ev_ch) begin m_pw = pw; m_mode = 0; end
          else begin m_left--; if (m_left == 0) m_mode = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] model_outputs();
    logic [2:0] st;
    logic [1:0] tr;
    st = 3'(m_mode);
    tr = 2'(MAX_TRIES - m_fails);
    return {st, (m_mode == 1), (m_mode == 4), (m_mode == 3), tr};
  endfunction

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic drive_cycle(input bit rst, input bit en, input bit ch, input logic [3:0] pw);
    Reset = rst; enter = en; change = ch; userpass = pw;
    model_step(rst, en, ch, pw);
    if (score_on) exp_q.push_back(model_outputs());
    @(posedge Clock);
    #1;
  endtask

  // ---------------- checks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input int op, input int al,
                           input int nw, input int tr);
    check({tag, ".state"}, state_o, st);
    check({tag, ".open"}, OPEN, op);
    check({tag, ".alarm"}, ALARM, al);
    check({tag, ".new"}, NEW, nw);
    check({tag, ".tries"}, tries_left, tr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst, en, ch;
    logic [3:0] pw;
    int         st, op, al, nw, tr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit en, input bit ch, input logic [3:0] pw,
                     input int st, input int op, input int al, input int nw, input int tr);
    vec_t v;
    v.rst = rst; v.en = en; v.ch = ch; v.pw = pw;
    v.st = st; v.op = op; v.al = al; v.nw = nw; v.tr = tr;
    vecs.push_back(v);
  endtask

  initial begin
    Reset = 1'b1; enter = 1'b0; change = 1'b0; userpass = '0;

    // Three wrong passwords raise the alarm; afterwards inputs are ignored.
    add(1,0,0,4'd0,  0,0,0,0,3);
    add(0,0,0,4'd0,  0,0,0,0,3);
    add(0,1,0,4'd1,  0,0,0,0,2);
    add(0,0,0,4'd1,  0,0,0,0,2);
    add(0,1,0,4'd2,  0,0,0,0,1);
    add(0,0,0,4'd2,  0,0,0,0,1);
    add(0,1,0,4'd3,  4,0,1,0,0);
    add(0,0,0,4'd3,  4,0,1,0,0);
    add(0,1,0,4'd6,  4,0,1,0,0);
    add(0,0,1,4'd6,  4,0,1,0,0);
    add(0,0,0,4'd6,  4,0,1,0,0);
    // Change password to 1010 via CHG_AUTH, then use it.
    add(1,0,0,4'd0,  0,0,0,0,3);
    add(0,0,0,4'd0,  0,0,0,0,3);
    add(0,0,1,4'd0,  2,0,0,0,3);
    add(0,0,0,4'd0,  2,0,0,0,3);
    add(0,0,1,4'd6,  3,0,0,1,3);
    add(0,0,0,4'd6,  3,0,0,1,3);
    add(0,1,0,4'd10, 0,0,0,0,3);
    add(0,0,0,4'd10, 0,0,0,0,3);
    add(0,1,0,4'd10, 1,1,0,0,3);
    add(0,0,0,4'd10, 1,1,0,0,3);
    add(0,1,0,4'd10, 0,0,0,0,3);
    add(0,0,0,4'd6,  0,0,0,0,3);
    add(0,1,0,4'd6,  0,0,0,0,2);
    add(0,0,0,4'd6,  0,0,0,0,2);
    // Reset restores 0110; simultaneous press goes to UNLOCKED.
    add(1,0,0,4'd0,  0,0,0,0,3);
    add(0,0,0,4'd0,  0,0,0,0,3);
    add(0,1,1,4'd6,  1,1,0,0,3);
    add(0,0,0,4'd6,  1,1,0,0,3);
    add(0,0,0,4'd6,  1,1,0,0,3);
    // Fail count shared between IDLE and CHG_AUTH, cleared on success.
    add(1,0,0,4'd0,  0,0,0,0,3);
    add(0,0,0,4'd0,  0,0,0,0,3);
    add(0,1,0,4'd1,  0,0,0,0,2);
    add(0,0,0,4'd1,  0,0,0,0,2);
    add(0,0,1,4'd1,  2,0,0,0,2);
    add(0,0,0,4'd1,  2,0,0,0,2);
    add(0,1,0,4'd1,  2,0,0,0,1);
    add(0,0,0,4'd1,  2,0,0,0,1);
    add(0,1,0,4'd6,  3,0,0,1,3);
    add(0,0,0,4'd6,  3,0,0,1,3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].rst, vecs[i].en, vecs[i].ch, vecs[i].pw);
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].op, vecs[i].al, vecs[i].nw, vecs[i].tr);
    end

    // Enter held through reset gives no event; a fresh press opens for 8 cycles.
    drive_cycle(1, 1, 0, DEF_PW);
    drive_cycle(1, 1, 0, DEF_PW);
    drive_cycle(0, 1, 0, DEF_PW);
    check_out("held_after_reset", 0, 0, 0, 0, 3);
    drive_cycle(0, 0, 0, DEF_PW);
    check_out("held_released", 0, 0, 0, 0, 3);
    drive_cycle(0, 1, 0, DEF_PW);
    check_out("open_c1", 1, 1, 0, 0, 3);
    for (int i = 2; i <= OPEN_CYCLES; i++) begin
      drive_cycle(0, 0, 0, DEF_PW);
      check_out($sformatf("open_c%0d", i), 1, 1, 0, 0, 3);
    end
    drive_cycle(0, 0, 0, DEF_PW);
    check_out("open_relock", 0, 0, 0, 0, 3);

    // From UNLOCKED, change then 32 quiet cycles: NEW times out, pw unchanged.
    drive_cycle(0, 1, 0, DEF_PW);
    check_out("chg_open", 1, 1, 0, 0, 3);
    drive_cycle(0, 0, 1, 4'd9);
    check_out("chg_new_c1", 3, 0, 0, 1, 3);
    for (int i = 2; i <= TIMEOUT_CYCLES; i++) begin
      drive_cycle(0, 0, 0, 4'd9);
      check_out($sformatf("chg_new_c%0d", i), 3, 0, 0, 1, 3);
    end
    drive_cycle(0, 0, 0, 4'd9);
    check_out("chg_new_timeout", 0, 0, 0, 0, 3);
    drive_cycle(0, 1, 0, DEF_PW);
    check_out("chg_new_pw_kept", 1, 1, 0, 0, 3);

    // Event on the last open cycle (timer at 0) is honoured over expiry.
    for (int i = 2; i <= OPEN_CYCLES; i++) drive_cycle(0, 0, 0, 4'd5);
    drive_cycle(0, 0, 1, 4'd5);
    check_out("edge_event", 3, 0, 0, 1, 3);
    drive_cycle(0, 1, 0, 4'd5);
    check_out("edge_commit", 0, 0, 0, 0, 3);
    drive_cycle(0, 0, 0, 4'd5);
    drive_cycle(0, 1, 0, 4'd5);
    check_out("edge_new_pw", 1, 1, 0, 0, 3);

    // CHG_AUTH timeout keeps the fail count.
    drive_cycle(1, 0, 0, 4'd0);
    drive_cycle(0, 0, 0, 4'd0);
    drive_cycle(0, 1, 0, 4'd1);
    drive_cycle(0, 0, 0, 4'd1);
    drive_cycle(0, 0, 1, 4'd1);
    check_out("auth_c1", 2, 0, 0, 0, 2);
    for (int i = 2; i <= TIMEOUT_CYCLES; i++) drive_cycle(0, 0, 0, 4'd1);
    check_out("auth_last", 2, 0, 0, 0, 2);
    drive_cycle(0, 0, 0, 4'd1);
    check_out("auth_timeout", 0, 0, 0, 0, 2);

    // Randomized run against the model through the expected queue.
    drive_cycle(1, 0, 0, 4'd0);
    score_on = 1'b1;
    begin
      bit quiet;
      bit rst, en, ch;
      logic [3:0] pw;
      logic [7:0] exp;
      quiet = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if (i % 100 == 0) quiet = ($urandom_range(0, 2) == 0);
        rst = ($urandom_range(0, 149) == 0);
        if (quiet) begin
          en = ($urandom_range(0, 59) == 0);
          ch = ($urandom_range(0, 59) == 0);
        end else begin
          en = ($urandom_range(0, 2) == 0);
          ch = ($urandom_range(0, 3) == 0);
        end
        pw = ($urandom_range(0, 2) == 0) ? m_pw : 4'($urandom_range(0, 15));
        drive_cycle(rst, en, ch, pw);
        exp = exp_q.pop_front();
        check_out($sformatf("rnd%0d", i), exp[7:5], exp[4], exp[3], exp[2], exp[1:0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
